sevseg_scan: RTL and testbench
==============================

// Module: sevseg_scan
// PURPOSE
//  Time-multiplexed 4-digit seven-segment driver for Basys3. Consumes 4 BCD digits
//  (MM:SS or SS.hh) from the stopwatch/timer counter and drives the active-low
//  anode, segment and dp pins. Latches the digits once per scan frame so no digit
//  tears mid-frame. Sits directly downstream of the up/down counter.
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency
//  DIGIT_HZ    1_000        per-digit dwell rate; frame rate = DIGIT_HZ/4
//  (localparam TICK_DIV = CLK_HZ/DIGIT_HZ, must be >= 2; elaboration error otherwise)
// PORTS
//  clk       in   1   system clock, single domain
//  reset     in   1   synchronous, active-high
//  digits_i  in   16  BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3
//  dp_i      in   4   decimal point enable per digit, 1=lit, bit n -> digit n
//  blank_i   in   1   1 = all anodes off (display dark)
//  an        out  4   anode select, active-low, bit n -> digit n
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp        out  1   decimal point, active-low
//  frame_o   out  1   1-cycle pulse when a new frame (digit 0) starts and inputs are latched
// BEHAVIOUR
//  - Reset: prescaler=0, idx=3, shadow regs=0, an=4'b1111, seg=7'h7F, dp=1, frame_o=0.
//  - Prescaler counts 0..TICK_DIV-1, wraps; tick = (cnt==TICK_DIV-1). First tick
//    occurs TICK_DIV cycles after reset deasserts.
//  - On a tick edge: idx <= idx+1 mod 4 (3->0 wraps). an/seg/dp are registered and
//    switch on that same edge to the new idx; all outputs are stable between ticks.
//  - Frame start (tick with idx==3): digits_i, dp_i captured into shadow regs;
//    digit 0 shown that edge uses the freshly captured value (decode from inputs);
//    frame_o=1 for exactly that one cycle. Inputs changing at other times have
//    no effect until the next frame start.
//  - an = ~(1<<idx) unless blank_i (sampled on every tick edge) -> an=4'b1111;
//    seg/dp still update while blanked. blank_i takes effect at the next tick.
//  - Decode: 0-9 standard patterns (0 -> 7'b1000000, 8 -> 7'b0000000); values
//    10-15 show dash (g only: 7'b0111111).
//  - dp = ~shadow_dp[idx].
//  - Reset asserted mid-frame: all state returns to reset values next edge.
// CONFIGURATION
//  SEVSEG_LZB_EN defined: leading-zero blanking. Digit n (n=3..1) has its anode
//    held off when it and all higher digits equal 0 in the shadow regs; digit 0
//    is never blanked; the dp bit of a blanked digit is also suppressed.
//  Not defined: all four digits always lit (subject to blank_i).
// STRUCTURE
//  - stopwatch_pkg: localparam NUM_DIGITS=4, BCD digit typedef (4-bit), segment
//    pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
//  - Sub-module bcd_to_seg: combinational 4-bit -> 7-bit active-low decoder,
//    shared with any other display path in the design.
//  - Top: prescaler, 2-bit idx, shadow regs, output registers.
// TESTING (bench with CLK_HZ=4000, DIGIT_HZ=1000 -> TICK_DIV=4)
//  1 reset, digits_i=16'h1234 -> an=1111 for 4 cycles; then an=1110 seg=7'b0011001
//    (4), frame_o=1 one cycle; then 1101/'3', 1011/'2', 0111/'1', each for 4 cycles.
//  2 change digits_i 1234->5678 while idx=1 -> digits 2,3 still show '2','1';
//    '8' appears only at next frame_o.
//  3 digits_i=16'h00AF -> digit0,1 show dash 7'b0111111; dp_i=4'b0100 -> dp=0 only
//    while an=1011.
//  4 blank_i=1 -> an=1111 from next tick onward, frame_o keeps pulsing every 16
//    cycles; blank_i=0 -> scanning resumes at next tick.
//  5 reset pulsed mid-frame (idx=2) -> next edge an=1111, seg=7F, dp=1; first
//    frame_o 4 cycles after reset release.
//  6 SEVSEG_LZB_EN, digits_i=16'h0040 -> digits 3 stays dark (an never 0111), digit
//    1 lit '4', digit 0 '0'; digits_i=16'h0000 -> only digit 0 lit; without
//    macro all four lit.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared display constants for the stopwatch/timer design.
// Digit count, BCD digit type and active-low {g,f,e,d,c,b,a} patterns.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: digit (4-bit BCD in), seg (7-bit {g..a} out); 10-15 show a dash.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  bcd_t digit,
  output seg_t seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevseg_scan.sv
// 4-digit multiplexed seven-segment scanner with per-frame input latching.
// Ports: clk, reset (sync, high), digits_i[15:0], dp_i[3:0], blank_i in;
// an[3:0], seg[6:0], dp (all active-low), frame_o out.
// Macro SEVSEG_LZB_EN enables leading-zero blanking of digits 3..1.
module sevseg_scan
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_i,
  output logic [3:0]  an,
  output seg_t        seg,
  output logic        dp,
  output logic        frame_o
);

  localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("sevseg_scan: TICK_DIV must be >= 2");
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nx;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_dp;
  logic          tick;
  logic          frame;
  logic [15:0]   cur_digits;
  logic [3:0]    cur_dp;
  logic [3:0]    lz;
  logic          hide;
  bcd_t          digit_nx;
  seg_t          seg_nx;
  logic [3:0]    an_nx;
  logic          dp_nx;

  assign tick   = (cnt == CW'(TICK_DIV - 1));
  assign frame  = tick & (idx == 2'd3);
  assign idx_nx = idx + 2'd1;

  // Digit 0 of a new frame decodes straight from the inputs being latched.
  assign cur_digits = frame ? digits_i : sh_digits;
  assign cur_dp     = frame ? dp_i : sh_dp;
  assign digit_nx   = cur_digits[{idx_nx, 2'b00} +: 4];

  always_comb begin
    lz = 4'b0000;
`ifdef SEVSEG_LZB_EN
    lz[3] = (cur_digits[15:12] == 4'd0);
    lz[2] = lz[3] & (cur_digits[11:8] == 4'd0);
    lz[1] = lz[2] & (cur_digits[7:4] == 4'd0);
`endif
  end

  assign hide  = lz[idx_nx];
  assign an_nx = (blank_i | hide) ? 4'b1111 : ~(4'b0001 << idx_nx);
  assign dp_nx = ~cur_dp[idx_nx] | hide;

  bcd_to_seg u_dec (
    .digit (digit_nx),
    .seg   (seg_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= 2'd3;
      sh_digits <= '0;
      sh_dp     <= '0;
      an        <= 4'b1111;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      frame_o <= frame;
      if (tick) begin
        idx <= idx_nx;
        an  <= an_nx;
        seg <= seg_nx;
        dp  <= dp_nx;
      end
      if (frame) begin
        sh_digits <= digits_i;
        sh_dp     <= dp_i;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan.sv
// Scoreboard bench for sevseg_scan at TICK_DIV=4.
// Expected per-cycle outputs are queued by cycle number and popped by a monitor.
module tb_sevseg_scan;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SD = 7'b0111111;

`ifdef SEVSEG_LZB_EN
  localparam logic [3:0] OFF_AF = 4'b1100;
  localparam logic [3:0] DPL_AF = 4'b1111;
  localparam logic [3:0] OFF_40 = 4'b1100;
  localparam logic [3:0] OFF_00 = 4'b1110;
`else
  localparam logic [3:0] OFF_AF = 4'b0000;
  localparam logic [3:0] DPL_AF = 4'b1011;
  localparam logic [3:0] OFF_40 = 4'b0000;
  localparam logic [3:0] OFF_00 = 4'b0000;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        blank_i;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_o;

  sevseg_scan #(
    .CLK_HZ   (4000),
    .DIGIT_HZ (1000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .frame_o  (frame_o)
  );

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c != cyc || an !== e.an || seg !== e.seg ||
          dp !== e.dp || frame_o !== e.fr) begin
        failures++;
        $display("FAIL scan cyc=%0d exp_cyc=%0d got an=%b seg=%b dp=%b fr=%b want an=%b seg=%b dp=%b fr=%b",
                 cyc, e.c, an, seg, dp, frame_o, e.an, e.seg, e.dp, e.fr);
      end
    end
  end

  task automatic exp_at(input int c, input logic [3:0] a,
                        input logic [6:0] s, input logic d,
                        input logic f);
    exp_t e;
    e.c = c;
    e.an = a;
    e.seg = s;
    e.dp = d;
    e.fr = f;
    q.push_back(e);
  endtask

  task automatic exp_rst(input int c0, input int c1);
    for (int c = c0; c <= c1; c++)
      exp_at(c, 4'b1111, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic exp_frame(input int f,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] off, input logic [3:0] dpl);
    logic [6:0] s [4];
    logic [3:0] a;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    s[3] = s3;
    for (int n = 0; n < 4; n++) begin
      a = off[n] ? 4'b1111 : ~(4'b0001 << n);
      for (int k = 0; k < 4; k++)
        exp_at(f + 4 * n + k, a, s[n], dpl[n], (n == 0 && k == 0));
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int rc, rc2;
    int f1, f2, f3, f4, f5, f6, f7, f8, f9, f10;
    reset = 1'b1;
    digits_i = 16'h1234;
    dp_i = 4'b0000;
    blank_i = 1'b0;

    rc = 3;
    f1 = rc + 4;
    f2 = f1 + 16;
    f3 = f2 + 16;
    f4 = f3 + 16;
    f5 = f4 + 16;
    f6 = f5 + 16;
    f7 = f6 + 16;
    rc2 = f7 + 11;
    f8 = rc2 + 4;
    f9 = f8 + 16;
    f10 = f9 + 16;

    exp_rst(1, rc + 3);
    exp_frame(f1, S4, S3, S2, S1, 4'b0000, 4'b1111);
    exp_frame(f2, S4, S3, S2, S1, 4'b0000, 4'b1111);
    goto(rc);
    reset = 1'b0;

    goto(f2 + 5);
    digits_i = 16'h5678;
    exp_frame(f3, S8, S7, S6, S5, 4'b0000, 4'b1111);

    goto(f3 + 6);
    digits_i = 16'h00AF;
    dp_i = 4'b0100;
    exp_frame(f4, SD, SD, S0, S0, OFF_AF, DPL_AF);

    goto(f4 + 1);
    exp_frame(f5, SD, SD, S0, S0, OFF_AF | 4'b1110, DPL_AF);
    exp_frame(f6, SD, SD, S0, S0, OFF_AF | 4'b0111, DPL_AF);
    goto(f5 + 2);
    blank_i = 1'b1;
    goto(f6 + 10);
    blank_i = 1'b0;

    goto(f6 + 14);
    digits_i = 16'h1234;
    dp_i = 4'b0000;
    for (int k = 0; k < 4; k++)
      exp_at(f7 + k, 4'b1110, S4, 1'b1, k == 0);
    for (int k = 4; k < 8; k++)
      exp_at(f7 + k, 4'b1101, S3, 1'b1, 1'b0);
    exp_at(f7 + 8, 4'b1011, S2, 1'b1, 1'b0);
    exp_at(f7 + 9, 4'b1011, S2, 1'b1, 1'b0);
    exp_rst(f7 + 10, rc2 + 3);
    exp_frame(f8, S4, S3, S2, S1, 4'b0000, 4'b1111);
    goto(f7 + 9);
    reset = 1'b1;
    goto(rc2);
    reset = 1'b0;

    goto(f8 + 2);
    digits_i = 16'h0040;
    exp_frame(f9, S0, S4, S0, S0, OFF_40, 4'b1111);

    goto(f9 + 2);
    digits_i = 16'h0000;
    exp_frame(f10, S0, S0, S0, S0, OFF_00, 4'b1111);

    goto(f10 + 17);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
